jk_cmd_seq: RTL and testbench

JK_CMD_SEQ -- requirements
Module: jk_cmd_seq

---
 rtl/jk_pkg.sv | 29 ++
 rtl/jk_cmd_seq_if.sv | 28 ++
 rtl/jk_cmd_fifo.sv | 48 ++++
 rtl/jk_cmd_seq.sv | 120 ++++++++++++
 tb/tb_jk_cmd_seq.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/jk_pkg.sv
// Shared types for the JK command sequencer.
// Op encoding doubles as the {j,k} drive pair.
package jk_pkg;

  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_CLEAR  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } jk_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_ISSUE
  } jk_state_e;

  function automatic logic [1:0] op_to_jk(jk_op_e op);
    logic [1:0] jk;
    unique case (op)
      OP_HOLD:   jk = 2'b00;
      OP_CLEAR:  jk = 2'b01;
      OP_SET:    jk = 2'b10;
      OP_TOGGLE: jk = 2'b11;
      default:   jk = 2'b00;
    endcase
    return jk;
  endfunction

endpackage

// File: rtl/jk_cmd_seq_if.sv
// Command valid/ready channel into the sequencer.
// master = command producer, slave = sequencer.
interface jk_cmd_seq_if
  import jk_pkg::*;
#(
  parameter int CNT_W = 4
);

  logic             cmd_valid;
  logic             cmd_ready;
  jk_op_e           cmd_op;
  logic [CNT_W-1:0] cmd_len;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_len,
    output cmd_ready
  );

endinterface

// File: rtl/jk_cmd_fifo.sv
// Small synchronous command FIFO.
// Pointers carry an extra wrap bit to tell full from empty.
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];
  logic         do_push;
  logic         do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/jk_cmd_seq.sv
// Queues JK commands, drives j/k for each command's length,
// and predicts/checks the downstream flop's q.
module jk_cmd_seq
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  jk_cmd_seq_if.slave        cmd,
  output logic               j,
  output logic               k,
  input  logic               q_in,
  output logic               busy,
  output logic               exp_q,
  output logic               exp_valid,
  output logic               mismatch
);

  localparam int W = 2 + CNT_W;

  jk_state_e        state;
  logic [CNT_W-1:0] remcnt;
  logic [W-1:0]     head;
  jk_op_e           head_op;
  logic [CNT_W-1:0] head_len;
  logic [CNT_W-1:0] first_rem;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign cmd.cmd_ready = !full;
  assign push = cmd.cmd_valid && !full;

  // Head is taken from IDLE, or back-to-back on the last ISSUE cycle.
  assign pop = !empty &&
               ((state == ST_IDLE) || (remcnt == '0));

  assign head_op   = jk_op_e'(head[W-1 -: 2]);
  assign head_len  = head[CNT_W-1:0];
  assign first_rem = (head_len == '0) ? '0
                   : head_len - CNT_W'(1);

  jk_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({cmd.cmd_op, cmd.cmd_len}),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      remcnt <= '0;
      j      <= 1'b0;
      k      <= 1'b0;
      busy   <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (!empty) begin
            {j, k} <= op_to_jk(head_op);
            remcnt <= first_rem;
            busy   <= 1'b1;
            state  <= ST_ISSUE;
          end else begin
            j <= 1'b0;
            k <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (remcnt != '0) begin
            remcnt <= remcnt - CNT_W'(1);
          end else if (!empty) begin
            {j, k} <= op_to_jk(head_op);
            remcnt <= first_rem;
          end else begin
            j     <= 1'b0;
            k     <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q     <= 1'b0;
      exp_valid <= 1'b0;
      mismatch  <= 1'b0;
    end else begin
      if (exp_valid && (q_in != exp_q)) mismatch <= 1'b1;
      unique case ({j, k})
        2'b01: begin
          exp_q     <= 1'b0;
          exp_valid <= 1'b1;
        end
        2'b10: begin
          exp_q     <= 1'b1;
          exp_valid <= 1'b1;
        end
        2'b11: exp_q <= ~exp_q;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_seq.sv
// Directed bench for jk_cmd_seq with a behavioural jk_ff
// closing the q_in loop; flip forces a wrong q_in.
module tb_jk_cmd_seq;
  import jk_pkg::*;

  logic clk;
  logic rst_n;
  logic j;
  logic k;
  logic q_in;
  logic busy;
  logic exp_q;
  logic exp_valid;
  logic mismatch;
  logic ff_q;
  logic flip;

  int n_cmp = 0;
  int n_err = 0;

  jk_cmd_seq_if #(.CNT_W(4)) cif ();

  jk_cmd_seq #(
    .DEPTH (4),
    .CNT_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd       (cif),
    .j         (j),
    .k         (k),
    .q_in      (q_in),
    .busy      (busy),
    .exp_q     (exp_q),
    .exp_valid (exp_valid),
    .mismatch  (mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= 1'b0;
    else begin
      unique case ({j, k})
        2'b01:   ff_q <= 1'b0;
        2'b10:   ff_q <= 1'b1;
        2'b11:   ff_q <= ~ff_q;
        default: ff_q <= ff_q;
      endcase
    end
  end

  assign q_in = ff_q ^ flip;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input jk_op_e op,
                       input logic [3:0] len);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_len   = len;
  endtask

  initial begin
    logic [4:0] tog_seq;
    rst_n = 1'b0;
    flip  = 1'b0;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = OP_HOLD;
    cif.cmd_len   = '0;
    #1;
    chk("rst_jk", {j, k}, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_expq", exp_q, 1'b0);
    chk("rst_expv", exp_valid, 1'b0);
    chk("rst_mis", mismatch, 1'b0);
    chk("rst_rdy", cif.cmd_ready, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // SET len=3 accepted on first edge after release
    drive(OP_SET, 4'd3);
    tick();
    cif.cmd_valid = 1'b0;
    chk("t1_e1_jk", {j, k}, 2'b00);
    chk("t1_e1_busy", busy, 1'b0);
    tick();
    chk("t1_e2_jk", {j, k}, 2'b10);
    chk("t1_e2_busy", busy, 1'b1);
    chk("t1_e2_expv", exp_valid, 1'b0);
    tick();
    chk("t1_e3_jk", {j, k}, 2'b10);
    chk("t1_e3_expq", exp_q, 1'b1);
    chk("t1_e3_expv", exp_valid, 1'b1);
    tick();
    chk("t1_e4_jk", {j, k}, 2'b10);
    chk("t1_e4_busy", busy, 1'b1);
    tick();
    chk("t1_e5_jk", {j, k}, 2'b00);
    chk("t1_e5_busy", busy, 1'b0);
    chk("t1_e5_expq", exp_q, 1'b1);

    // back-to-back SET 1, CLEAR 2, TOGGLE 0
    drive(OP_SET, 4'd1);
    tick();
    drive(OP_CLEAR, 4'd2);
    tick();
    chk("t2_jk0", {j, k}, 2'b10);
    drive(OP_TOGGLE, 4'd0);
    tick();
    cif.cmd_valid = 1'b0;
    chk("t2_jk1", {j, k}, 2'b01);
    tick();
    chk("t2_jk2", {j, k}, 2'b01);
    tick();
    chk("t2_jk3", {j, k}, 2'b11);
    chk("t2_busy3", busy, 1'b1);
    tick();
    chk("t2_jk_end", {j, k}, 2'b00);
    chk("t2_busy_end", busy, 1'b0);
    tick();
    chk("t2_expq", exp_q, 1'b1);
    chk("t2_busy_idle", busy, 1'b0);

    // SET then TOGGLE x4 with the jk_ff in the loop
    drive(OP_SET, 4'd1);
    tick();
    drive(OP_TOGGLE, 4'd4);
    tick();
    cif.cmd_valid = 1'b0;
    chk("t3_jk_set", {j, k}, 2'b10);
    tog_seq = 5'b10101;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t3_expq%0d", i), exp_q, tog_seq[4-i]);
      chk($sformatf("t3_qin%0d", i), q_in, tog_seq[4-i]);
    end
    chk("t3_mis", mismatch, 1'b0);
    chk("t3_jk_end", {j, k}, 2'b00);

    // fill the FIFO behind a long HOLD command
    drive(OP_HOLD, 4'd15);
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("t4_rdy_c3", cif.cmd_ready, 1'b1);
    tick();
    chk("t4_rdy_full", cif.cmd_ready, 1'b0);
    for (int i = 0; i < 6; i++) tick();
    chk("t4_rdy_c10", cif.cmd_ready, 1'b0);
    chk("t4_busy_c10", busy, 1'b1);
    for (int i = 0; i < 6; i++) tick();
    chk("t4_rdy_pop", cif.cmd_ready, 1'b1);
    tick();
    chk("t4_rdy_refill", cif.cmd_ready, 1'b0);
    cif.cmd_valid = 1'b0;

    // reset flushes queue
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_busy", busy, 1'b0);
    chk("t4_rst_rdy", cif.cmd_ready, 1'b1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t4_post_busy%0d", i), busy, 1'b0);
    end

    // forced q_in error after CLEAR
    drive(OP_CLEAR, 4'd1);
    tick();
    cif.cmd_valid = 1'b0;
    tick();
    chk("t5_jk", {j, k}, 2'b01);
    tick();
    chk("t5_expv", exp_valid, 1'b1);
    chk("t5_expq", exp_q, 1'b0);
    chk("t5_mis0", mismatch, 1'b0);
    flip = 1'b1;
    tick();
    flip = 1'b0;
    chk("t5_mis1", mismatch, 1'b1);
    for (int i = 0; i < 3; i++) tick();
    chk("t5_mis_sticky", mismatch, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("t5_mis_rst", mismatch, 1'b0);
    chk("t5_expv_rst", exp_valid, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // reset mid TOGGLE len=8 with two queued
    drive(OP_TOGGLE, 4'd8);
    tick();
    drive(OP_SET, 4'd2);
    tick();
    chk("t6_jk_tog", {j, k}, 2'b11);
    drive(OP_CLEAR, 4'd2);
    tick();
    cif.cmd_valid = 1'b0;
    tick();
    tick();
    chk("t6_jk_mid", {j, k}, 2'b11);
    chk("t6_busy_mid", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_jk", {j, k}, 2'b00);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_rdy", cif.cmd_ready, 1'b1);
    chk("t6_rst_expq", exp_q, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("t6_post_jk%0d", i), {j, k}, 2'b00);
      chk($sformatf("t6_post_busy%0d", i), busy, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
